// File: rtl/dvs_refractory_event_buffer.sv
// dvs_refractory_event_buffer
//   Per-pixel refractory filter feeding an inline circular event FIFO.
//   Each pixel remembers the timestamp of its last accepted event; a new
//   event from the same pixel is discarded if it arrives within refract_i
//   ticks. Accepted events are queued in a show-ahead FIFO. When the FIFO is
//   full the input either back-pressures (drop_mode_i=0) or stays ready and
//   discards the event (drop_mode_i=1). Two saturating counters record
//   filter drops and overflow drops.
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   refract_i               refractory window in ticks (0 disables filter)
//   drop_mode_i             full policy: 0 backpressure, 1 drop
//   clear_stats_i           synchronous clear of both drop counters
//   valid_i/ready_o         input handshake; x_i, y_i, polarity_i, timestamp_i
//   valid_o/ready_i         output handshake; x_o, y_o, polarity_o, timestamp_o
//   count_o                 FIFO occupancy
//   filt_drops_o            events removed by the refractory filter
//   ovf_drops_o             events dropped on full in drop mode
module dvs_refractory_event_buffer #(
  parameter int WIDTH_P      = 8,
  parameter int HEIGHT_P     = 8,
  parameter int DEPTH_LOG2_P = 4,
  parameter int STAT_W_P     = 16,
  localparam int XW = $clog2(WIDTH_P),
  localparam int YW = $clog2(HEIGHT_P)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [15:0]             refract_i,
  input  logic                    drop_mode_i,
  input  logic                    clear_stats_i,
  input  logic                    valid_i,
  input  logic [XW-1:0]           x_i,
  input  logic [YW-1:0]           y_i,
  input  logic                    polarity_i,
  input  logic [15:0]             timestamp_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [XW-1:0]           x_o,
  output logic [YW-1:0]           y_o,
  output logic                    polarity_o,
  output logic [15:0]             timestamp_o,
  input  logic                    ready_i,
  output logic [DEPTH_LOG2_P:0]   count_o,
  output logic [STAT_W_P-1:0]     filt_drops_o,
  output logic [STAT_W_P-1:0]     ovf_drops_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2_P;
  localparam int NPIX  = WIDTH_P * HEIGHT_P;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          pol;
    logic [15:0]   ts;
  } event_t;

  event_t                  mem [DEPTH];
  logic [DEPTH_LOG2_P-1:0] wr_ptr;
  logic [DEPTH_LOG2_P-1:0] rd_ptr;
  logic [DEPTH_LOG2_P:0]   count;
  logic [15:0]             last_ts [NPIX];
  logic [NPIX-1:0]         seen;
  logic [STAT_W_P-1:0]     filt_cnt;
  logic [STAT_W_P-1:0]     ovf_cnt;

  logic [PW-1:0] pix;
  logic [15:0]   age;
  logic          full;
  logic          fire;
  logic          pass;
  logic          push;
  logic          pop;
  logic          filt_inc;
  logic          ovf_inc;

  // Saturating increment shared by both drop counters.
  function automatic logic [STAT_W_P-1:0] sat_inc(input logic [STAT_W_P-1:0] v);
    return (&v) ? v : v + STAT_W_P'(1);
  endfunction

  // Pixel index is column-major; out-of-range coordinates are not guarded.
  assign pix  = PW'(x_i) * PW'(HEIGHT_P) + PW'(y_i);
  // Modular subtraction makes the age correct across timestamp wrap.
  assign age  = timestamp_i - last_ts[pix];
  assign pass = ~seen[pix] | (refract_i == 16'd0) | (age >= refract_i);

  assign full     = (count == (DEPTH_LOG2_P + 1)'(DEPTH));
  assign ready_o  = drop_mode_i | ~full;
  assign fire     = valid_i & ready_o;
  // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
  assign push     = fire & pass & ~full;
  assign filt_inc = fire & ~pass;
  assign ovf_inc  = fire & pass & full;

  assign valid_o  = (count != '0);
  assign pop      = valid_o & ready_i;

  assign x_o          = mem[rd_ptr].x;
  assign y_o          = mem[rd_ptr].y;
  assign polarity_o   = mem[rd_ptr].pol;
  assign timestamp_o  = mem[rd_ptr].ts;
  assign count_o      = count;
  assign filt_drops_o = filt_cnt;
  assign ovf_drops_o  = ovf_cnt;

  // FIFO pointers, occupancy, seen flags and drop statistics.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seen     <= '0;
      filt_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + DEPTH_LOG2_P'(1);
        seen[pix] <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2_P'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2_P + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2_P + 1)'(1);
        default: count <= count;
      endcase
      // Clear takes priority over a coincident increment.
      if (clear_stats_i) begin
        filt_cnt <= '0;
        ovf_cnt  <= '0;
      end else begin
        if (filt_inc) filt_cnt <= sat_inc(filt_cnt);
        if (ovf_inc)  ovf_cnt  <= sat_inc(ovf_cnt);
      end
    end
  end

  // Event storage and last-accepted timestamps; validity is tracked elsewhere.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr]  <= '{x: x_i, y: y_i, pol: polarity_i, ts: timestamp_i};
      last_ts[pix] <= timestamp_i;
    end
  end

endmodule

// File: tb/tb_dvs_refractory_event_buffer.sv
// Testbench for dvs_refractory_event_buffer: scoreboard queue of expected
// output events, filled when stimulus is accepted and drained by a monitor.
module tb_dvs_refractory_event_buffer;

  localparam int SW    = 4;
  localparam int SMAX  = 15;
  localparam int PASS  = 0;
  localparam int FILT  = 1;
  localparam int OVF   = 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [15:0]   refract_i = 16'd0;
  logic          drop_mode_i = 1'b0;
  logic          clear_stats_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [2:0]    x_i = 3'd0;
  logic [2:0]    y_i = 3'd0;
  logic          polarity_i = 1'b0;
  logic [15:0]   timestamp_i = 16'd0;
  logic          ready_o;
  logic          valid_o;
  logic [2:0]    x_o;
  logic [2:0]    y_o;
  logic          polarity_o;
  logic [15:0]   timestamp_o;
  logic          ready_i = 1'b0;
  logic [4:0]    count_o;
  logic [SW-1:0] filt_drops_o;
  logic [SW-1:0] ovf_drops_o;

  dvs_refractory_event_buffer #(.STAT_W_P(SW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .refract_i(refract_i),
    .drop_mode_i(drop_mode_i), .clear_stats_i(clear_stats_i),
    .valid_i(valid_i), .x_i(x_i), .y_i(y_i), .polarity_i(polarity_i),
    .timestamp_i(timestamp_i), .ready_o(ready_o), .valid_o(valid_o),
    .x_o(x_o), .y_o(y_o), .polarity_o(polarity_o), .timestamp_o(timestamp_o),
    .ready_i(ready_i), .count_o(count_o), .filt_drops_o(filt_drops_o),
    .ovf_drops_o(ovf_drops_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  x;
    logic [2:0]  y;
    logic        p;
    logic [15:0] ts;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_filt = 0;
  int  exp_ovf = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare the head event whenever the DUT will pop it at the next edge.
  always @(negedge clk_i) begin
    ev_t e;
    if (!reset_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("out_x", 32'(x_o), 32'(e.x));
        check_val("out_y", 32'(y_o), 32'(e.y));
        check_val("out_pol", 32'(polarity_o), 32'(e.p));
        check_val("out_ts", 32'(timestamp_o), 32'(e.ts));
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    exp_q.delete();
    exp_filt = 0;
    exp_ovf = 0;
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_count", 32'(count_o), 32'd0);
    check_val("rst_filt", 32'(filt_drops_o), 32'd0);
    check_val("rst_ovf", 32'(ovf_drops_o), 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  // Present one event, wait (bounded) for ready, record the expected outcome.
  task automatic send(input int x, input int y, input int p, input int ts,
                      input int outcome, input bit clr);
    ev_t e;
    bit  got;
    got = 1'b0;
    e.x = 3'(x);
    e.y = 3'(y);
    e.p = 1'(p);
    e.ts = 16'(ts);
    x_i = e.x;
    y_i = e.y;
    polarity_i = e.p;
    timestamp_i = e.ts;
    valid_i = 1'b1;
    clear_stats_i = clr;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check_val("send_timeout", 32'd0, 32'd1);
      valid_i = 1'b0;
      clear_stats_i = 1'b0;
      @(posedge clk_i); #1;
      return;
    end
    if (outcome == PASS) exp_q.push_back(e);
    if (clr) begin
      exp_filt = 0;
      exp_ovf = 0;
    end else if (outcome == FILT) begin
      if (exp_filt < SMAX) exp_filt++;
    end else if (outcome == OVF) begin
      if (exp_ovf < SMAX) exp_ovf++;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    clear_stats_i = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    @(negedge clk_i);
    check_val({tag, "_filt"}, 32'(filt_drops_o), 32'(exp_filt));
    check_val({tag, "_ovf"}, 32'(ovf_drops_o), 32'(exp_ovf));
    @(posedge clk_i); #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (count_o == 5'd0 && exp_q.size() == 0) break;
    end
    check_val({tag, "_count"}, 32'(count_o), 32'd0);
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    do_reset();

    // 1: single event, one-cycle latency, then popped
    refract_i = 16'd0;
    drop_mode_i = 1'b0;
    ready_i = 1'b1;
    send(3, 5, 1, 100, PASS, 1'b0);
    check_val("t1_valid", 32'(valid_o), 32'd1);
    check_val("t1_count1", 32'(count_o), 32'd1);
    @(posedge clk_i); #1;
    check_val("t1_count0", 32'(count_o), 32'd0);
    check_val("t1_valid0", 32'(valid_o), 32'd0);

    // 2: refractory filter on one pixel, independent neighbour
    refract_i = 16'd10;
    send(2, 2, 0, 100, PASS, 1'b0);
    send(2, 2, 1, 105, FILT, 1'b0);
    check_stats("t2a");
    send(2, 2, 0, 110, PASS, 1'b0);
    send(4, 1, 0, 101, PASS, 1'b0);
    check_stats("t2b");

    // 3: timestamp wrap
    send(6, 7, 0, 65530, PASS, 1'b0);
    send(6, 7, 0, 3, FILT, 1'b0);
    send(6, 7, 1, 4, PASS, 1'b0);
    check_stats("t3");
    wait_drain("t3");

    // 4: backpressure fill and ordered drain
    refract_i = 16'd0;
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(i % 8, i / 8, i & 1, 200 + i, PASS, 1'b0);
    check_val("t4_count16", 32'(count_o), 32'd16);
    x_i = 3'd0; y_i = 3'd2; polarity_i = 1'b0; timestamp_i = 16'd216;
    valid_i = 1'b1;
    @(negedge clk_i);
    check_val("t4_ready_low", 32'(ready_o), 32'd0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check_val("t4_still16", 32'(count_o), 32'd16);
    ready_i = 1'b1;
    for (int i = 16; i < 20; i++) send(i % 8, i / 8, i & 1, 200 + i, PASS, 1'b0);
    wait_drain("t4");
    check_stats("t4");

    // 5: drop mode overflow; dropped pixels stay unseen
    do_reset();
    refract_i = 16'd1000;
    drop_mode_i = 1'b1;
    ready_i = 1'b0;
    for (int i = 0; i < 20; i++) send(i % 8, i / 8, 0, 10 + i, (i < 16) ? PASS : OVF, 1'b0);
    check_val("t5_count16", 32'(count_o), 32'd16);
    check_val("t5_ready_drop", 32'(ready_o), 32'd1);
    check_stats("t5a");
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check_val("t5_count15", 32'(count_o), 32'd15);
    send(0, 2, 0, 40, PASS, 1'b0);
    check_val("t5_refill", 32'(count_o), 32'd16);
    send(0, 0, 1, 41, FILT, 1'b0);
    check_stats("t5b");

    // 6: saturation, clear priority, mid-stream reset
    for (int i = 20; i < 31; i++) send(i % 8, i / 8, 0, 50 + i, OVF, 1'b0);
    check_stats("t6_max");
    send(7, 3, 0, 81, OVF, 1'b0);
    check_val("t6_sat", 32'(ovf_drops_o), 32'(SMAX));
    send(0, 4, 0, 90, OVF, 1'b1);
    check_stats("t6_clear");
    check_val("t6_prerst", 32'(count_o), 32'd16);
    do_reset();
    send(0, 0, 0, 95, PASS, 1'b0);
    check_val("t6_postrst", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    wait_drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
